// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: state encoding shared by the shift sequencer and its bench
package shift_seq_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHIFT  = 3'd1,
    PARITY = 3'd2,
    FLUSH  = 3'd3,
    DONE   = 3'd4
  } state_t;
endpackage

// File: rtl/shift_seq_counter.sv
// shift_seq_counter: bit counter with clear, increment and terminal-count compare
module shift_seq_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [CW-1:0] limit,
  output logic [CW-1:0] count,
  output logic          last
);
  logic [CW-1:0] count_q, count_d;
  always_comb count_d = clear ? '0 : inc ? count_q + CW'(1) : count_q;
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  assign count = count_q;
  assign last  = count_q == limit;
endmodule

// File: rtl/shift_sequencer.sv
// shift_sequencer: serializes a word MSB first, then flushes a DEPTH-stage downstream register.
// Optional even-parity bit after the payload when SHIFT_SEQUENCER_PARITY_EN is defined.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             ser_out,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH + DEPTH + 1);
  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic [CW-1:0]    count, limit, idx;
  logic             last, clear, inc, ser_bit;
  shift_seq_counter #(.CW(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (inc),
    .limit (limit),
    .count (count),
    .last  (last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (in_valid) state_d = SHIFT;
`ifdef SHIFT_SEQUENCER_PARITY_EN
      SHIFT:  if (last) state_d = PARITY;
      PARITY: state_d = FLUSH;
`else
      SHIFT:  if (last) state_d = FLUSH;
`endif
      FLUSH:  if (last) state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) state_d = IDLE;
    hold_d = (in_valid && in_ready) ? in_data : hold_q;
  end
  // The counter restarts on every state change, so it only ever counts within one state.
  assign clear   = state_d != state_q;
  assign inc     = state_q == SHIFT || state_q == FLUSH;
  assign limit   = state_q == SHIFT ? CW'(WIDTH - 1) : CW'(DEPTH - 1);
  assign idx     = CW'(WIDTH - 1) - count;
  assign ser_bit = 1'(hold_q >> idx);
  always_comb begin
    in_ready = state_q == IDLE && !rst;
    busy     = state_q != IDLE;
    done     = state_q == DONE;
`ifdef SHIFT_SEQUENCER_PARITY_EN
    shift_en = state_q == SHIFT || state_q == PARITY || state_q == FLUSH;
    ser_out  = state_q == SHIFT ? ser_bit : state_q == PARITY ? ^hold_q : 1'b0;
`else
    shift_en = state_q == SHIFT || state_q == FLUSH;
    ser_out  = state_q == SHIFT ? ser_bit : 1'b0;
`endif
  end
endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, number of bits per serialized word (legal range 2..32).
REQ-002 SHALL have parameter DEPTH, default 4, stage count of the downstream serial shift register to be flushed (legal range 1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_data  input  WIDTH  parallel word to serialize.
REQ-006 SHALL have port in_valid  input  1  in_data is offered.
REQ-007 SHALL have port in_ready  output  1  sequencer accepts a word this cycle.
REQ-008 SHALL have port abort  input  1  cancel the current transfer.
REQ-009 SHALL have port ser_out  output  1  serial bit driven to the downstream shift register input.
REQ-010 SHALL have port shift_en  output  1  high while ser_out carries a payload, parity or flush bit.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when the last payload bit has emerged from the downstream register.

Function
REQ-013 SHALL implement states IDLE, SHIFT, PARITY (macro only), FLUSH, DONE, all registered.
REQ-014 SHALL drive in_ready = 1 only in IDLE with rst low; a transfer is accepted on an edge where in_valid and in_ready are both 1.
REQ-015 SHALL, on acceptance, capture in_data into an internal WIDTH-bit holding register and move IDLE->SHIFT.
REQ-016 SHALL, in SHIFT, present bits MSB first: the first SHIFT cycle drives ser_out = in_data[WIDTH-1], and the last drives in_data[0], for exactly WIDTH cycles with shift_en = 1.
REQ-017 SHALL use a bit counter of width clog2(WIDTH+DEPTH+1); it SHALL wrap to 0 at every state exit and SHALL never overflow.
REQ-018 SHALL move SHIFT->FLUSH after the WIDTH-th bit, or SHIFT->PARITY when the parity feature is compiled in.
REQ-019 SHALL, in FLUSH, drive ser_out = 0 and shift_en = 1 for exactly DEPTH cycles, then move to DONE.
REQ-020 SHALL assert done = 1 for exactly one cycle in DONE, then move DONE->IDLE unconditionally.
REQ-021 SHALL ignore in_valid outside IDLE; a word held during busy is accepted on the first IDLE cycle.
REQ-022 SHALL, when abort = 1 in any state except IDLE, go to IDLE on the next edge with no done pulse; abort wins over a simultaneous DONE->IDLE, and abort in IDLE has no effect.
REQ-023 SHALL treat in_valid and abort both high in IDLE as a normal acceptance.
REQ-024 SHALL give a fixed latency of WIDTH+DEPTH+1 cycles (WIDTH+DEPTH+2 with parity) from the accepting edge to the done pulse.
REQ-025 SHALL drive ser_out = 0 and shift_en = 0 in IDLE and DONE.

Reset
REQ-026 SHALL, on rst = 1 at a rising edge, force state = IDLE, counter = 0, holding register = 0, ser_out = 0, shift_en = 0, busy = 0 and done = 0.
REQ-027 SHALL, when rst is asserted mid-transfer, discard the transfer with no done pulse and hold in_ready = 0 while rst is high.

Configuration
REQ-028 SHALL honour macro SHIFT_SEQUENCER_PARITY_EN: when defined, a PARITY state follows SHIFT for one cycle with shift_en = 1 and ser_out = XOR of the captured word (even parity).
REQ-029 SHALL, without SHIFT_SEQUENCER_PARITY_EN, contain no PARITY state or parity logic, and SHIFT SHALL go directly to FLUSH.

Structure
REQ-030 SHALL place the state encoding type and the state constants (IDLE = 0, SHIFT = 1, PARITY = 2, FLUSH = 3, DONE = 4) in shared package shift_seq_pkg.
REQ-031 SHALL keep the bit counter and its terminal-count compare in one sub-module, shift_seq_counter, with ports clk, rst, clear, inc and count.

Verification
REQ-032 SHALL cover this case: WIDTH = 16, DEPTH = 4, in_data = 16'h5F0A accepted at edge 0 -> ser_out shows 0101111100001010 on cycles 1-16, zeros on cycles 17-20, and done on cycle 21.
REQ-033 SHALL cover this case: in_valid held high during a busy transfer with a second word 16'hFFFF -> in_ready stays 0 until IDLE, then the second word is accepted and serialized as sixteen 1s.
REQ-034 SHALL cover this case: abort at SHIFT cycle 5 -> next cycle busy = 0, shift_en = 0 and in_ready = 1, with no done pulse.
REQ-035 SHALL cover this case: rst asserted during FLUSH -> all outputs are 0 on the next edge and no done pulse follows.
REQ-036 SHALL cover this case: with SHIFT_SEQUENCER_PARITY_EN defined and in_data = 16'h5F0A (eight 1s) -> ser_out = 0 on cycle 17, done on cycle 22.
REQ-037 SHALL cover this case: back-to-back words with in_valid held high -> consecutive done pulses are exactly WIDTH+DEPTH+2 cycles apart.
